// File: rtl/window_result_collector.sv
// -----------------------------------------------------------------------------
// window_result_collector
//
// Downstream end of the sliding-window convolution path. One signed filter
// result arrives per pixel pushed into the window, in raster order. Results
// from partially filled windows are dropped: those in the first K-1 rows and
// the first K-1 columns of every row. Each surviving result is packed to
// WORD_SIZE bits and written to the output frame buffer. The write address is
// linear over an (ROW_WIDTH-K+1) x (NUM_ROWS-K+1) image.
//
// The upstream pipeline cannot stall. A small FIFO therefore absorbs
// frame-buffer backpressure. If the FIFO is full and no pop happens in the
// same cycle, a kept result is dropped and the sticky overflow flag is set.
// The output index still advances, so later addresses remain geometrically
// correct.
//
// Optional feature macro: CLAMP_EN
//   defined   : results saturate to the unsigned range [0, 2^WORD_SIZE-1]
//   undefined : results are truncated to their low WORD_SIZE bits
//
// Ports
//   clk         in   clock; all logic runs on the rising edge
//   reset       in   synchronous, active-high reset
//   start       in   begin collecting a new frame (honoured only in IDLE)
//   in_valid    in   in_data is valid (one per pixel pushed into the window)
//   in_data     in   signed filter result for the window ending at this pixel
//   wr_ready    in   frame buffer accepts a write this cycle
//   wr_en       out  write request; a transfer occurs on wr_en && wr_ready
//   wr_addr     out  linear output address (FIFO head)
//   wr_data     out  packed pixel (FIFO head)
//   busy        out  high while collecting (RUN) or draining (DRAIN)
//   frame_done  out  one-cycle pulse after the last write of the frame
//   overflow    out  sticky: a kept result was lost to a full FIFO
// -----------------------------------------------------------------------------
module window_result_collector #(
  parameter int KERNEL_SIZE = 3,
  parameter int ROW_WIDTH   = 800,
  parameter int NUM_ROWS    = 600,
  parameter int WORD_SIZE   = 8,
  parameter int ACC_WIDTH   = 16,
  parameter int FIFO_DEPTH  = 8,
  localparam int OUT_W      = ROW_WIDTH - KERNEL_SIZE + 1,
  localparam int OUT_H      = NUM_ROWS - KERNEL_SIZE + 1,
  localparam int AW         = (OUT_W * OUT_H > 1) ? $clog2(OUT_W * OUT_H) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        in_valid,
  input  logic signed [ACC_WIDTH-1:0] in_data,
  input  logic                        wr_ready,
  output logic                        wr_en,
  output logic [AW-1:0]               wr_addr,
  output logic [WORD_SIZE-1:0]        wr_data,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        overflow
);

  localparam int CW   = (ROW_WIDTH > 1) ? $clog2(ROW_WIDTH) : 1;
  localparam int RW   = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = PW + 1;
  localparam int EW   = AW + WORD_SIZE;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [CW-1:0]   COL_LAST = CW'(ROW_WIDTH - 1);
  localparam logic [CW-1:0]   COL_KEEP = CW'(KERNEL_SIZE - 1);
  localparam logic [RW-1:0]   ROW_LAST = RW'(NUM_ROWS - 1);
  localparam logic [RW-1:0]   ROW_KEEP = RW'(KERNEL_SIZE - 1);
  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(FIFO_DEPTH);

`ifdef CLAMP_EN
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((2 ** WORD_SIZE) - 1);
`endif

  // Reduce a signed filter result to an output pixel.
  function automatic logic [WORD_SIZE-1:0] pack_word(input logic signed [ACC_WIDTH-1:0] v);
    logic [WORD_SIZE-1:0] r;
`ifdef CLAMP_EN
    if (v[ACC_WIDTH-1]) begin
      r = '0;
    end else if (v > SAT_MAX) begin
      r = '1;
    end else begin
      r = v[WORD_SIZE-1:0];
    end
`else
    r = v[WORD_SIZE-1:0];
`endif
    return r;
  endfunction

  logic [1:0]           state_q, state_d;
  logic [CW-1:0]        col_q, col_d;
  logic [RW-1:0]        row_q, row_d;
  logic [AW-1:0]        idx_q, idx_d;
  logic                 ovf_q, ovf_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 wr_en_q, wr_en_d;
  logic [PW-1:0]        wptr_q, wptr_d;
  logic [PW-1:0]        rptr_q, rptr_d;
  logic [CNTW-1:0]      cnt_q, cnt_d;
  logic [EW-1:0]        mem_q [FIFO_DEPTH];

  logic accept_s, keep_s, full_s, pop_s, push_s, drop_s;

  // The keep decision uses the pre-increment column and row.
  // A push into a full FIFO is still legal when the head leaves in the same cycle.
  assign accept_s = (state_q == S_RUN) && in_valid;
  assign keep_s   = accept_s && (col_q >= COL_KEEP) && (row_q >= ROW_KEEP);
  assign full_s   = (cnt_q == CNT_FULL);
  assign pop_s    = (cnt_q != '0) && wr_ready;
  assign push_s   = keep_s && (!full_s || pop_s);
  assign drop_s   = keep_s && full_s && !pop_s;

  // FIFO pointer and occupancy next-state.
  always_comb begin
    wptr_d = push_s ? (wptr_q + PW'(1)) : wptr_q;
    rptr_d = pop_s ? (rptr_q + PW'(1)) : rptr_q;
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + CNTW'(1);
      2'b01:   cnt_d = cnt_q - CNTW'(1);
      default: cnt_d = cnt_q;
    endcase
    wr_en_d = (cnt_d != '0);
  end

  // Frame FSM, raster position and output index next-state.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    idx_d   = idx_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          col_d   = '0;
          row_d   = '0;
          idx_d   = '0;
          ovf_d   = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (in_valid) begin
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              state_d = S_DRAIN;
            end else begin
              row_d = row_q + RW'(1);
            end
          end else begin
            col_d = col_q + CW'(1);
          end
          // Dropped results still consume an address.
          if (keep_s) begin
            idx_d = idx_q + AW'(1);
          end else begin
            idx_d = idx_q;
          end
          if (drop_s) begin
            ovf_d = 1'b1;
          end else begin
            ovf_d = ovf_q;
          end
        end else begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        // Leave on the edge that empties the FIFO. frame_done then follows the
        // last write by one cycle.
        if (cnt_d == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
  end

  // State, counters, FIFO storage and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      wr_en_q <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      wr_en_q <= wr_en_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      if (push_s) begin
        mem_q[wptr_q] <= {idx_q, pack_word(in_data)};
      end
    end
  end

  assign wr_en                = wr_en_q;
  assign {wr_addr, wr_data}   = mem_q[rptr_q];
  assign busy                 = busy_q;
  assign frame_done           = done_q;
  assign overflow             = ovf_q;

endmodule

// File: tb/tb_window_result_collector.sv
// -----------------------------------------------------------------------------
// tb_window_result_collector
//
// Directed bench for window_result_collector with a 5x5 input frame, K=3 and
// a 4-entry FIFO. The output image is 3x3. A monitor on the falling edge
// records every write transfer and every frame_done pulse. It also checks
// that the FIFO head stays put while the frame buffer stalls. The expected
// values are written out by hand.
// -----------------------------------------------------------------------------
module tb_window_result_collector;

  localparam int K   = 3;
  localparam int RWD = 5;
  localparam int NR  = 5;
  localparam int WS  = 8;
  localparam int ACW = 16;
  localparam int FD  = 4;
  localparam int AW  = 4;

  logic           clk = 1'b0;
  logic           reset, start, in_valid, wr_ready;
  logic [ACW-1:0] in_data;
  logic           wr_en, busy, frame_done, overflow;
  logic [AW-1:0]  wr_addr;
  logic [WS-1:0]  wr_data;

  window_result_collector #(
    .KERNEL_SIZE(K), .ROW_WIDTH(RWD), .NUM_ROWS(NR),
    .WORD_SIZE(WS), .ACC_WIDTH(ACW), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_data(in_data), .wr_ready(wr_ready), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .frame_done(frame_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  int            wa_q[$];
  int            wd_q[$];
  int            fd_cnt = 0;
  int            last_wr_cyc = 0;
  int            fd_cyc = 0;
  logic          prev_stall = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [WS-1:0] prev_data = '0;
  logic          toggle = 1'b0;

  logic [ACW-1:0] din [25];
  int             exp_data [9];

  // Monitor: write transfers, frame_done pulses and head stability while stalled.
  always @(negedge clk) begin
    if (prev_stall) begin
      check("hold_en", wr_en, 1);
      check("hold_addr", wr_addr, prev_addr);
      check("hold_data", wr_data, prev_data);
    end
    if (wr_en && wr_ready && !reset) begin
      wa_q.push_back(int'(wr_addr));
      wd_q.push_back(int'(wr_data));
      last_wr_cyc = cyc;
    end
    if (frame_done && !reset) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
    prev_stall = wr_en && !wr_ready && !reset;
    prev_addr  = wr_addr;
    prev_data  = wr_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (toggle) wr_ready = ~wr_ready;
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    fd_cnt = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    tick(); tick();
    reset = 1'b0;
    clear_log();
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic feed(input int from, input int to);
    for (int i = from; i <= to; i++) begin
      in_valid = 1'b1; in_data = din[i]; tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic set_default();
    int ed [9];
    ed = '{13, 14, 15, 18, 19, 20, 23, 24, 25};
    for (int i = 0; i < 25; i++) din[i] = ACW'(i + 1);
    for (int i = 0; i < 9; i++) exp_data[i] = ed[i];
  endtask

  task automatic wait_done();
    int n = 0;
    while (fd_cnt == 0 && n < 200) begin tick(); n++; end
    tick(); tick();
    check("done_once", fd_cnt, 1);
    check("done_latency", fd_cyc - last_wr_cyc, 1);
    check("busy_end", busy, 0);
  endtask

  task automatic check_writes(input int n);
    check("n_writes", wa_q.size(), n);
    for (int i = 0; i < n && i < wa_q.size(); i++) begin
      check($sformatf("addr%0d", i), wa_q[i], i);
      check($sformatf("data%0d", i), wd_q[i], exp_data[i]);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; wr_ready = 1'b1;
    set_default();

    // Nominal frame with the frame buffer always ready.
    do_reset();
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_overflow", overflow, 0);
    do_start();
    check("busy_run", busy, 1);
    feed(0, 24);
    wait_done();
    check_writes(9);
    check("ovf_nominal", overflow, 0);

    // Frame buffer blocked across the whole frame: only FD entries survive.
    wr_ready = 1'b0;
    do_reset();
    do_start();
    feed(0, 24);
    while (cyc < 40) tick();
    check("ovf_blocked", overflow, 1);
    check("wr_en_blocked", wr_en, 1);
    check("no_write_blocked", wa_q.size(), 0);
    wr_ready = 1'b1;
    wait_done();
    check_writes(4);
    check("ovf_sticky", overflow, 1);

    // Frame buffer ready every other cycle.
    do_reset();
    toggle = 1'b1;
    do_start();
    feed(0, 24);
    wait_done();
    toggle = 1'b0;
    wr_ready = 1'b1;
    check_writes(9);
    check("ovf_toggle", overflow, 0);

    // Packing at the first three kept positions.
    din[12] = 16'hFFFB;
    din[13] = 16'd300;
    din[14] = 16'd77;
`ifdef CLAMP_EN
    exp_data[0] = 0; exp_data[1] = 255; exp_data[2] = 77;
`else
    exp_data[0] = 251; exp_data[1] = 44; exp_data[2] = 77;
`endif
    do_reset();
    do_start();
    feed(0, 24);
    wait_done();
    check_writes(9);
    set_default();

    // Reset mid-frame discards buffered results.
    wr_ready = 1'b0;
    do_reset();
    do_start();
    feed(0, 14);
    check("wr_en_mid", wr_en, 1);
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    check("mid_rst_wr_en", wr_en, 0);
    check("mid_rst_busy", busy, 0);
    wr_ready = 1'b1;
    clear_log();
    tick(); tick(); tick();
    check("no_stale", wa_q.size(), 0);
    do_start();
    feed(0, 24);
    wait_done();
    check_writes(9);

    // in_valid in IDLE and start during RUN are ignored.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 16'd99; tick();
      in_valid = 1'b0; tick();
    end
    check("idle_busy", busy, 0);
    check("idle_wr_en", wr_en, 0);
    check("idle_no_write", wa_q.size(), 0);
    do_start();
    feed(0, 6);
    start = 1'b1; tick(); start = 1'b0;
    check("busy_after_restart", busy, 1);
    feed(7, 24);
    wait_done();
    check_writes(9);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
